id_stage: RTL and testbench

Instruction-decode stage of the five-stage MIPS pipeline, directly downstream of the fetch stage. It holds the IF/ID pipeline register, the 32×32 register file and the load-use/branch hazard detector. It resolves beq/bne/jr/j early in decode and returns the branch decision, jump field, shifted immediate, rs value and stall/flush controls to the fetch stage. Opcode/func go to the controller, and operands go to the ID/EX register.

---
 rtl/mips_pkg.sv | 41 ++++
 rtl/reg_file.sv | 36 +++
 rtl/id_stage.sv | 107 ++++++++++
 tb/tb_id_stage.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: field widths, opcode/func values,
// jump-select encodings and the IF/ID register layout.
package mips_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 1 << REG_AW;

    // Word placed in IF/ID on reset and on a squash (sll $0,$0,0).
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;

    // Controller jump select.
    typedef enum logic [1:0] {
        JMP_NONE = 2'b00,
        JMP_J    = 2'b01,
        JMP_JR   = 2'b10
    } jmp_e;

    // IF/ID pipeline register contents.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
    } ifid_t;

    function automatic logic [XLEN-1:0] sign_ext16(input logic [15:0] imm);
        return {{(XLEN-16){imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports with write-through,
// one write port committed at the clock edge, $0 hard-wired to zero.
module reg_file
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [XLEN-1:0]   wd,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic [XLEN-1:0]   rd1,
    output logic [XLEN-1:0]   rd2
);

    logic [NUM_REGS-1:0][XLEN-1:0] regs_q;

    // Write port; writes to $0 are dropped so entry 0 stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '0;
        end else if (we && (wa != '0)) begin
            regs_q[wa] <= wd;
        end
    end

    // Read ports bypass the pending write so WB and ID can share a cycle.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != '0) rd1 = (we && (wa == ra1)) ? wd : regs_q[ra1];
        if (ra2 != '0) rd2 = (we && (wa == ra2)) ? wd : regs_q[ra2];
    end

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: IF/ID register, register file, hazard detection and
// early resolution of beq/bne/j/jr back to fetch.
module id_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   if_instr,
    input  logic [XLEN-1:0]   if_pc4,
    input  logic              Branch,
    input  logic              not_equal_Branch,
    input  logic [1:0]        Jmp,
    input  logic              ex_memread,
    input  logic              ex_regwrite,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              mem_memread,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic [5:0]        opcode,
    output logic [5:0]        func,
    output logic [REG_AW-1:0] rs,
    output logic [REG_AW-1:0] rt,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   read_data1_reg,
    output logic [XLEN-1:0]   read_data2_reg,
    output logic [XLEN-1:0]   inst_extended,
    output logic [XLEN-1:0]   shifted_inst_extended,
    output logic [25:0]       Id_instruction,
    output logic [XLEN-1:0]   id_pc4,
    output logic              and_z_b,
    output logic              stall,
    output logic              flush
);

    ifid_t ifid_q, ifid_d;

    logic  is_br, is_jr, load_use, br_stall, equal;

    // IF/ID next state: stall holds, flush squashes, otherwise capture fetch.
    always_comb begin
        ifid_d = ifid_q;
        if (!stall) begin
            if (flush) begin
                ifid_d.instr = NOP_INSTR;
                ifid_d.pc4   = '0;
            end else begin
                ifid_d.instr = if_instr;
                ifid_d.pc4   = if_pc4;
            end
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifid_q.instr <= NOP_INSTR;
            ifid_q.pc4   <= '0;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign opcode                = ifid_q.instr[31:26];
    assign rs                    = ifid_q.instr[25:21];
    assign rt                    = ifid_q.instr[20:16];
    assign rd                    = ifid_q.instr[15:11];
    assign func                  = ifid_q.instr[5:0];
    assign Id_instruction        = ifid_q.instr[25:0];
    assign id_pc4                = ifid_q.pc4;
    assign inst_extended         = sign_ext16(ifid_q.instr[15:0]);
    assign shifted_inst_extended = {inst_extended[XLEN-3:0], 2'b00};

    reg_file u_reg_file (
        .clk (clk),
        .rst (rst),
        .we  (wb_regwrite),
        .wa  (wb_rd),
        .wd  (wb_data),
        .ra1 (rs),
        .ra2 (rt),
        .rd1 (read_data1_reg),
        .rd2 (read_data2_reg)
    );

    // Hazards: load-use on any source, plus in-flight producers of the
    // operands that branches (rs, rt) and jr (rs only) compare in decode.
    always_comb begin
        is_br    = Branch | not_equal_Branch;
        is_jr    = (Jmp == JMP_JR);
        load_use = ex_memread && (ex_dst != '0) && ((ex_dst == rs) || (ex_dst == rt));
        br_stall = (is_br || is_jr) &&
                   ((ex_regwrite && (ex_dst != '0) &&
                     ((ex_dst == rs) || (is_br && (ex_dst == rt)))) ||
                    (mem_memread && (mem_dst != '0) &&
                     ((mem_dst == rs) || (is_br && (mem_dst == rt)))));
    end

    assign stall = load_use | br_stall;

    // Branch decision is gated by stall so stale operands never redirect.
    assign equal   = (read_data1_reg == read_data2_reg);
    assign and_z_b = ~stall & ((Branch & equal) | (not_equal_Branch & ~equal));
    assign flush   = ~stall & (and_z_b | (Jmp != JMP_NONE));

endmodule

// File: tb/tb_id_stage.sv
// Directed test of the decode stage: reset, register write-through,
// load-use stall, beq/bne resolution with hazards, j/jr and reset mid-stall.
module tb_id_stage;
    import mips_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] if_instr, if_pc4;
    logic        Branch, not_equal_Branch;
    logic [1:0]  Jmp;
    logic        ex_memread, ex_regwrite, mem_memread, wb_regwrite;
    logic [4:0]  ex_dst, mem_dst, wb_rd;
    logic [31:0] wb_data;
    logic [5:0]  opcode, func;
    logic [4:0]  rs, rt, rd;
    logic [31:0] read_data1_reg, read_data2_reg, inst_extended, shifted_inst_extended, id_pc4;
    logic [25:0] Id_instruction;
    logic        and_z_b, stall, flush;

    int n_tests = 0;
    int n_fail  = 0;

    id_stage dut (
        .clk(clk), .rst(rst), .if_instr(if_instr), .if_pc4(if_pc4),
        .Branch(Branch), .not_equal_Branch(not_equal_Branch), .Jmp(Jmp),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_dst(ex_dst),
        .mem_memread(mem_memread), .mem_dst(mem_dst),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .opcode(opcode), .func(func), .rs(rs), .rt(rt), .rd(rd),
        .read_data1_reg(read_data1_reg), .read_data2_reg(read_data2_reg),
        .inst_extended(inst_extended), .shifted_inst_extended(shifted_inst_extended),
        .Id_instruction(Id_instruction), .id_pc4(id_pc4),
        .and_z_b(and_z_b), .stall(stall), .flush(flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        if_instr = 32'h8C22_0004; if_pc4 = 32'h4;
        Branch = 0; not_equal_Branch = 0; Jmp = 2'b00;
        ex_memread = 0; ex_regwrite = 0; ex_dst = 0;
        mem_memread = 0; mem_dst = 0;
        wb_regwrite = 0; wb_rd = 0; wb_data = 0;

        // Reset with lw pending at fetch
        #3;
        chk("rst_opcode", {26'd0, opcode}, 32'h0);
        chk("rst_rs", {27'd0, rs}, 32'h0);
        chk("rst_rd1", read_data1_reg, 32'h0);
        chk("rst_ext", inst_extended, 32'h0);
        chk("rst_pc4", id_pc4, 32'h0);
        chk("rst_ctl", {29'd0, stall, flush, and_z_b}, 32'h0);
        @(posedge clk); #1;
        chk("rst_hold", {6'd0, Id_instruction}, 32'h0);
        #2 rst = 1'b1;
        tick();
        chk("lw_opcode", {26'd0, opcode}, 32'h23);
        chk("lw_rs", {27'd0, rs}, 32'h1);
        chk("lw_rt", {27'd0, rt}, 32'h2);
        chk("lw_ext", inst_extended, 32'h4);
        chk("lw_pc4", id_pc4, 32'h4);

        // Populate $1=7, $2=7, $4=3
        wb_regwrite = 1; wb_rd = 1; wb_data = 32'd7; tick();
        wb_rd = 2; tick();
        wb_rd = 4; wb_data = 32'd3; tick();
        wb_regwrite = 0; #1;
        chk("lw_rd1", read_data1_reg, 32'd7);
        chk("lw_rd2", read_data2_reg, 32'd7);

        // Write-through: add $3,$5,$0
        if_instr = 32'h00A0_1820; if_pc4 = 32'h10; tick();
        chk("add_func", {26'd0, func}, 32'h20);
        chk("add_rd", {27'd0, rd}, 32'h3);
        chk("r5_empty", read_data1_reg, 32'h0);
        wb_regwrite = 1; wb_rd = 5; wb_data = 32'hDEAD_BEEF; #1;
        chk("wt_rd1", read_data1_reg, 32'hDEAD_BEEF);
        tick();
        wb_rd = 0; wb_data = 32'hFFFF_FFFF; #1;
        chk("r0_wt", read_data2_reg, 32'h0);
        chk("r5_stored", read_data1_reg, 32'hDEAD_BEEF);
        tick();
        wb_regwrite = 0; #1;
        chk("r0_after", read_data2_reg, 32'h0);

        // Load-use: add $3,$2,$4 with lw $2 in EX
        if_instr = 32'h0044_1820; if_pc4 = 32'h20; tick();
        if_instr = 32'h2005_0009; if_pc4 = 32'h24;
        ex_memread = 1; ex_dst = 2; #1;
        chk("lu_stall", {31'd0, stall}, 32'h1);
        chk("lu_flush", {31'd0, flush}, 32'h0);
        tick();
        chk("lu_hold_rs", {27'd0, rs}, 32'h2);
        chk("lu_hold_pc", id_pc4, 32'h20);
        chk("lu_rd2", read_data2_reg, 32'd3);
        ex_dst = 0; #1;
        chk("lu_r0", {31'd0, stall}, 32'h0);
        ex_memread = 0; #1;
        chk("lu_clear", {31'd0, stall}, 32'h0);
        tick();
        chk("addi_op", {26'd0, opcode}, 32'h08);
        chk("addi_ext", inst_extended, 32'h9);

        // beq $1,$2,-2 taken
        if_instr = 32'h1022_FFFE; if_pc4 = 32'h100; tick();
        Branch = 1; if_instr = 32'h2005_0009; if_pc4 = 32'h104; #1;
        chk("beq_take", {31'd0, and_z_b}, 32'h1);
        chk("beq_flush", {31'd0, flush}, 32'h1);
        chk("beq_stall", {31'd0, stall}, 32'h0);
        chk("beq_ext", inst_extended, 32'hFFFF_FFFE);
        chk("beq_shift", shifted_inst_extended, 32'hFFFF_FFF8);
        chk("beq_pc4", id_pc4, 32'h100);
        tick();
        Branch = 0; #1;
        chk("beq_sq_op", {26'd0, opcode}, 32'h0);
        chk("beq_sq_ins", {6'd0, Id_instruction}, 32'h0);
        chk("beq_sq_pc", id_pc4, 32'h0);

        // bne $1,$2 with $2=9; ALU hazard on $1, then load in MEM on $2
        wb_regwrite = 1; wb_rd = 2; wb_data = 32'd9;
        if_instr = 32'h1422_0003; if_pc4 = 32'h200; tick();
        wb_regwrite = 0; not_equal_Branch = 1; ex_regwrite = 1; ex_dst = 1; #1;
        chk("bne_stall", {31'd0, stall}, 32'h1);
        chk("bne_gate", {31'd0, and_z_b}, 32'h0);
        chk("bne_nofl", {31'd0, flush}, 32'h0);
        ex_regwrite = 0; ex_dst = 0; mem_memread = 1; mem_dst = 2;
        if_instr = 32'h0800_0040; if_pc4 = 32'h204; #1;
        chk("bne_mem_st", {31'd0, stall}, 32'h1);
        tick();
        mem_memread = 0; mem_dst = 0; #1;
        chk("bne_clear", {31'd0, stall}, 32'h0);
        chk("bne_take", {31'd0, and_z_b}, 32'h1);
        chk("bne_flush", {31'd0, flush}, 32'h1);
        chk("bne_pc4", id_pc4, 32'h200);
        tick();
        not_equal_Branch = 0; #1;
        chk("bne_sq", {26'd0, opcode}, 32'h0);

        // j 0x40
        tick();
        Jmp = 2'b01; #1;
        chk("j_op", {26'd0, opcode}, 32'h02);
        chk("j_field", {6'd0, Id_instruction}, 32'h40);
        chk("j_flush", {31'd0, flush}, 32'h1);
        chk("j_nobr", {31'd0, and_z_b}, 32'h0);

        // jr $5 (rt field 4 to show rt is not a jr hazard)
        if_instr = 32'h00A4_0008; if_pc4 = 32'h300; tick();
        Jmp = 2'b00; #1;
        chk("j_sq", {26'd0, opcode}, 32'h0);
        tick();
        Jmp = 2'b10; #1;
        chk("jr_rd1", read_data1_reg, 32'hDEAD_BEEF);
        chk("jr_flush", {31'd0, flush}, 32'h1);
        ex_regwrite = 1; ex_dst = 4; #1;
        chk("jr_rt_ok", {31'd0, stall}, 32'h0);
        chk("jr_rt_fl", {31'd0, flush}, 32'h1);
        ex_dst = 5; #1;
        chk("jr_rs_st", {31'd0, stall}, 32'h1);
        chk("jr_rs_nf", {31'd0, flush}, 32'h0);

        // Reset mid-stall
        rst = 1'b0; #1;
        chk("mid_stall", {31'd0, stall}, 32'h0);
        chk("mid_br", {31'd0, and_z_b}, 32'h0);
        chk("mid_ins", {6'd0, Id_instruction}, 32'h0);
        chk("mid_pc4", id_pc4, 32'h0);
        Jmp = 2'b00; ex_regwrite = 0; ex_dst = 0;
        if_instr = 32'h00A0_1820; if_pc4 = 32'h10;
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("post_rs", {27'd0, rs}, 32'h5);
        chk("post_r5", read_data1_reg, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
